cordic_sweep_avalon_master: RTL

Avalon-MM master that drives the CORDIC Avalon slave across an angle sweep. For each angle it does one write-then-read transaction pair and unpacks the returned sin/cos word. Results go into an on-chip FIFO exposed as a valid/ready stream. It sits between a control source (CPU or test sequencer) and the CORDIC slave, replacing software polling.

---
 rtl/cordic_sweep_pkg.sv | 23 ++
 rtl/sweep_result_fifo.sv | 65 ++++++
 rtl/cordic_sweep_avalon_master.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cordic_sweep_pkg.sv
// Shared types and constants for the CORDIC sweep Avalon master.
package cordic_sweep_pkg;

  // Sweep sequencer states.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_WRITE      = 3'd2,
    S_SETTLE     = 3'd3,
    S_READ       = 3'd4
  } sweep_state_e;

  // Field positions inside the slave read word.
  localparam int SIN_LSB = 0;
  localparam int COS_LSB = 16;

  // Default parameter values.
  localparam int DEF_ANGLE_W    = 12;
  localparam int DEF_SETTLE     = 12;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/sweep_result_fifo.sv
// Synchronous show-ahead FIFO holding {index, cos, sin} sweep results.
module sweep_result_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s, do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values for accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/cordic_sweep_avalon_master.sv
// Avalon-MM master sweeping angles through a single-register CORDIC slave.
module cordic_sweep_avalon_master
  import cordic_sweep_pkg::*;
#(
  parameter int ANGLE_W    = DEF_ANGLE_W,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [ANGLE_W-1:0] angle_start,
  input  logic [ANGLE_W-1:0] angle_step,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic               av_chipselect,
  output logic               av_write,
  output logic               av_read,
  output logic [31:0]        av_writedata,
  input  logic [31:0]        av_readdata,
  input  logic               av_waitrequest,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ANGLE_W-1:0] res_sin,
  output logic [ANGLE_W-1:0] res_cos,
  output logic [CNT_W-1:0]   res_index
);

  localparam int SCNT_W  = $clog2(SETTLE + 1);
  localparam int ENTRY_W = CNT_W + 2 * ANGLE_W;

  sweep_state_e       state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d, step_q, step_d;
  logic [CNT_W-1:0]   count_q, count_d, idx_q, idx_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               push_s, pop_s, fifo_empty_s, fifo_full_s, unused_rdata_s;
  logic [ENTRY_W-1:0] push_data_s, head_s;

  assign push_data_s    = {idx_q, av_readdata[COS_LSB +: ANGLE_W], av_readdata[SIN_LSB +: ANGLE_W]};
  assign unused_rdata_s = ^av_readdata;
  assign pop_s          = !fifo_empty_s && res_ready;

  sweep_result_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .resetn      (resetn),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .head_o      (head_s)
  );

  // Stream outputs come straight from FIFO registers, forced to 0 while empty.
  assign res_valid = !fifo_empty_s;
  assign res_sin   = fifo_empty_s ? {ANGLE_W{1'b0}} : head_s[ANGLE_W-1:0];
  assign res_cos   = fifo_empty_s ? {ANGLE_W{1'b0}} : head_s[2*ANGLE_W-1:ANGLE_W];
  assign res_index = fifo_empty_s ? {CNT_W{1'b0}}   : head_s[ENTRY_W-1:2*ANGLE_W];

  assign busy          = busy_q;
  assign done          = done_q;
  assign av_chipselect = cs_q;
  assign av_write      = wr_q;
  assign av_read       = rd_q;
  assign av_writedata  = wdata_q;

  // Next-state, sweep bookkeeping and registered-output decode.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    step_d  = step_q;
    count_d = count_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    done_d  = 1'b0;
    push_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (count != {CNT_W{1'b0}})) begin
          angle_d = angle_start;
          step_d  = angle_step;
          count_d = count;
          idx_d   = {CNT_W{1'b0}};
          state_d = S_WAIT_SPACE;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_SPACE: begin
        // A write is only issued when its result is guaranteed a FIFO slot.
        if (!fifo_full_s) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT_SPACE;
        end
      end
      S_WRITE: begin
        if (!av_waitrequest) begin
          scnt_d  = SCNT_W'(SETTLE - 1);
          state_d = S_SETTLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_SETTLE: begin
        if (scnt_q == {SCNT_W{1'b0}}) begin
          state_d = S_READ;
        end else begin
          scnt_d = scnt_q - SCNT_W'(1);
        end
      end
      S_READ: begin
        if (!av_waitrequest) begin
          push_s = 1'b1;
          if (idx_q == (count_q - CNT_W'(1))) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            angle_d = angle_q + step_q;
            state_d = S_WAIT_SPACE;
          end
        end else begin
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Bus and status outputs are decoded from the next state and registered.
    busy_d  = (state_d != S_IDLE);
    wr_d    = (state_d == S_WRITE);
    rd_d    = (state_d == S_READ);
    cs_d    = wr_d || rd_d;
    wdata_d = wr_d ? {{(32-ANGLE_W){1'b0}}, angle_d} : 32'd0;
  end

  // State and output registers; reset abandons any bus cycle in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      angle_q <= {ANGLE_W{1'b0}};
      step_q  <= {ANGLE_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      idx_q   <= {CNT_W{1'b0}};
      scnt_q  <= {SCNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      step_q  <= step_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
